bp_fe_bp_resolve_queue: RTL and testbench

//  In-flight branch tracker directly upstream of the perceptron predictor's update port.

---
 rtl/bp_fe_bp_resolve_queue_pkg.sv | 24 ++
 rtl/bp_fe_bp_resolve_queue_if.sv | 47 ++++
 rtl/bp_fe_bp_circ_ptr.sv | 36 +++
 rtl/bp_fe_bp_resolve_queue.sv | 117 +++++++++++
 tb/tb_bp_fe_bp_resolve_queue.sv | 192 +++++++++++++++++++
 5 files changed

// File: rtl/bp_fe_bp_resolve_queue_pkg.sv
// -----------------------------------------------------------------------------
// bp_fe_bp_resolve_queue_pkg
//   Shared constants and helpers for the branch resolve queue and the
//   perceptron predictor it feeds.
//   Contents:
//     BHT_IDX_WIDTH_DEF / QUEUE_ELS_DEF : default geometry
//     ptr_width()                       : circular pointer width (index + wrap bit)
//     pred_correct()                    : predicted vs actual direction compare
// -----------------------------------------------------------------------------
package bp_fe_bp_resolve_queue_pkg;

   localparam int unsigned BHT_IDX_WIDTH_DEF = 2;
   localparam int unsigned QUEUE_ELS_DEF     = 4;

   // Index bits plus one wrap bit so full and empty are distinguishable.
   function automatic int unsigned ptr_width(input int unsigned els);
      return $clog2(els) + 1;
   endfunction

   function automatic logic pred_correct(input logic predicted, input logic actual);
      return (predicted == actual);
   endfunction

endpackage

// File: rtl/bp_fe_bp_resolve_queue_if.sv
// -----------------------------------------------------------------------------
// bp_fe_bp_resolve_queue_if
//   Bundles the prediction enqueue handshake, the backend resolution/flush
//   inputs and the training outputs of the resolve queue.
//   Modports:
//     master : frontend/backend side (drives pred_*, res_*, flush_i)
//     slave  : resolve queue side (drives pred_ready_o and training outputs)
//   Signals:
//     pred_v_i, pred_idx_i, pred_taken_i, pred_ready_o  prediction enqueue
//     res_v_i, res_taken_i                              in-order resolution
//     flush_i                                           squash all entries
//     w_v_o, idx_w_o, correct_o, mispredict_o           training event
//     count_o, underflow_o                              occupancy / sticky error
// -----------------------------------------------------------------------------
interface bp_fe_bp_resolve_queue_if
   import bp_fe_bp_resolve_queue_pkg::*;
#(
   parameter int unsigned bht_idx_width_p = BHT_IDX_WIDTH_DEF,
   parameter int unsigned queue_els_p     = QUEUE_ELS_DEF,
   localparam int unsigned cnt_width_lp   = $clog2(queue_els_p + 1)
);

   logic                       pred_v_i;
   logic [bht_idx_width_p-1:0] pred_idx_i;
   logic                       pred_taken_i;
   logic                       pred_ready_o;
   logic                       res_v_i;
   logic                       res_taken_i;
   logic                       flush_i;
   logic                       w_v_o;
   logic [bht_idx_width_p-1:0] idx_w_o;
   logic                       correct_o;
   logic                       mispredict_o;
   logic [cnt_width_lp-1:0]    count_o;
   logic                       underflow_o;

   modport master (
      output pred_v_i, pred_idx_i, pred_taken_i, res_v_i, res_taken_i, flush_i,
      input  pred_ready_o, w_v_o, idx_w_o, correct_o, mispredict_o, count_o, underflow_o
   );

   modport slave (
      input  pred_v_i, pred_idx_i, pred_taken_i, res_v_i, res_taken_i, flush_i,
      output pred_ready_o, w_v_o, idx_w_o, correct_o, mispredict_o, count_o, underflow_o
   );

endinterface

// File: rtl/bp_fe_bp_circ_ptr.sv
// -----------------------------------------------------------------------------
// bp_fe_bp_circ_ptr
//   Circular pointer over els_p slots with an extra wrap bit.
//   Ports:
//     clk_i   clock
//     reset_i synchronous active-high reset (pointer -> 0)
//     inc_i   advance by one slot
//     clr_i   return to 0 (has priority over inc_i)
//     ptr_o   {wrap, index}
// -----------------------------------------------------------------------------
module bp_fe_bp_circ_ptr
   import bp_fe_bp_resolve_queue_pkg::*;
#(
   parameter int unsigned els_p        = QUEUE_ELS_DEF,
   localparam int unsigned ptr_width_lp = ptr_width(els_p)
) (
   input  logic                    clk_i,
   input  logic                    reset_i,
   input  logic                    inc_i,
   input  logic                    clr_i,
   output logic [ptr_width_lp-1:0] ptr_o
);

   logic [ptr_width_lp-1:0] r_ptr;

   // els_p is a power of two, so natural binary overflow carries into the wrap bit.
   always_ff @(posedge clk_i) begin
      if (reset_i || clr_i)
         r_ptr <= '0;
      else if (inc_i)
         r_ptr <= r_ptr + ptr_width_lp'(1);
   end

   assign ptr_o = r_ptr;

endmodule

// File: rtl/bp_fe_bp_resolve_queue.sv
// -----------------------------------------------------------------------------
// bp_fe_bp_resolve_queue
//   In-flight branch tracker in front of the perceptron update port. Records
//   each issued prediction {index, direction} in program order, pairs it with
//   the in-order backend resolution and emits a registered training event.
//   Wrong-path entries are squashed on a misprediction or on flush_i.
//   Ports:
//     clk_i    clock
//     reset_i  synchronous active-high reset
//     bus      bp_fe_bp_resolve_queue_if.slave (enqueue, resolve, flush,
//              training outputs, occupancy, sticky underflow)
// -----------------------------------------------------------------------------
module bp_fe_bp_resolve_queue
   import bp_fe_bp_resolve_queue_pkg::*;
#(
   parameter int unsigned bht_idx_width_p = BHT_IDX_WIDTH_DEF,
   parameter int unsigned queue_els_p     = QUEUE_ELS_DEF,
   localparam int unsigned cnt_width_lp   = $clog2(queue_els_p + 1),
   localparam int unsigned ptr_width_lp   = ptr_width(queue_els_p),
   localparam int unsigned addr_width_lp  = ptr_width_lp - 1
) (
   input logic                    clk_i,
   input logic                    reset_i,
   bp_fe_bp_resolve_queue_if.slave bus
);

   typedef struct packed {
      logic [bht_idx_width_p-1:0] idx;
      logic                       taken;
   } bp_fe_bp_entry_s;

   bp_fe_bp_entry_s r_mem [queue_els_p];

   logic [ptr_width_lp-1:0] w_head;
   logic [ptr_width_lp-1:0] w_tail;
   logic                    w_empty;
   logic                    w_full;
   logic                    w_deq;
   logic                    w_enq;
   logic                    w_correct;
   logic                    w_mispredict;
   logic                    w_squash;
   bp_fe_bp_entry_s         w_head_entry;

   logic                       r_w_v;
   logic [bht_idx_width_p-1:0] r_idx_w;
   logic                       r_correct;
   logic                       r_mispredict;
   logic                       r_underflow;

   assign w_empty = (w_head == w_tail);
   assign w_full  = (w_head[addr_width_lp-1:0] == w_tail[addr_width_lp-1:0]) &&
                    (w_head[addr_width_lp] != w_tail[addr_width_lp]);

   assign w_head_entry = r_mem[w_head[addr_width_lp-1:0]];

   assign w_deq        = bus.res_v_i && !w_empty;
   assign w_correct    = pred_correct(w_head_entry.taken, bus.res_taken_i);
   assign w_mispredict = w_deq && !w_correct;

   // A mispredict pops the head and discards everything younger, which leaves
   // the queue empty; clearing both pointers is equivalent and simpler.
   assign w_squash = w_mispredict || bus.flush_i;
   assign w_enq    = bus.pred_v_i && !w_full && !w_squash;

   bp_fe_bp_circ_ptr #(.els_p(queue_els_p)) u_head_ptr (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .inc_i   (w_deq),
      .clr_i   (w_squash),
      .ptr_o   (w_head)
   );

   bp_fe_bp_circ_ptr #(.els_p(queue_els_p)) u_tail_ptr (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .inc_i   (w_enq),
      .clr_i   (w_squash),
      .ptr_o   (w_tail)
   );

   // Storage carries no reset; validity is defined solely by the pointers.
   always_ff @(posedge clk_i) begin
      if (w_enq) begin
         r_mem[w_tail[addr_width_lp-1:0]] <= '{idx: bus.pred_idx_i, taken: bus.pred_taken_i};
      end
   end

   // Training stage. idx_w_o/correct_o hold their last value between events.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         r_w_v        <= 1'b0;
         r_idx_w      <= '0;
         r_correct    <= 1'b0;
         r_mispredict <= 1'b0;
         r_underflow  <= 1'b0;
      end else begin
         r_w_v        <= w_deq;
         r_mispredict <= w_mispredict;
         if (w_deq) begin
            r_idx_w   <= w_head_entry.idx;
            r_correct <= w_correct;
         end
         if (bus.res_v_i && w_empty)
            r_underflow <= 1'b1;
      end
   end

   assign bus.pred_ready_o = !w_full;
   assign bus.w_v_o        = r_w_v;
   assign bus.idx_w_o      = r_idx_w;
   assign bus.correct_o    = r_correct;
   assign bus.mispredict_o = r_mispredict;
   assign bus.underflow_o  = r_underflow;
   assign bus.count_o      = cnt_width_lp'(w_tail - w_head);

endmodule

// File: tb/tb_bp_fe_bp_resolve_queue.sv
module tb_bp_fe_bp_resolve_queue;

   logic clk;
   logic rst;
   int unsigned n_checks;
   int unsigned n_fail;

   bp_fe_bp_resolve_queue_if #(.bht_idx_width_p(2), .queue_els_p(4)) bus ();

   bp_fe_bp_resolve_queue #(.bht_idx_width_p(2), .queue_els_p(4)) dut (
      .clk_i   (clk),
      .reset_i (rst),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      bus.pred_v_i     = 1'b0;
      bus.pred_idx_i   = '0;
      bus.pred_taken_i = 1'b0;
      bus.res_v_i      = 1'b0;
      bus.res_taken_i  = 1'b0;
      bus.flush_i      = 1'b0;
   endtask

   task automatic enq(input logic [1:0] idx, input logic taken);
      bus.pred_v_i     = 1'b1;
      bus.pred_idx_i   = idx;
      bus.pred_taken_i = taken;
      step();
      bus.pred_v_i     = 1'b0;
   endtask

   logic [1:0] exp_pop4 [10] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2};
   logic [1:0] exp_drain4 [3] = '{2'd3, 2'd0, 2'd1};
   logic       exp_taken2 [4] = '{1'b1, 1'b0, 1'b1, 1'b0};

   initial begin
      n_checks = 0;
      n_fail   = 0;
      idle_inputs();

      // 1: reset state, fill to full, 5th enqueue ignored
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
      step();
      check_eq("rst_count", bus.count_o, 0);
      check_eq("rst_ready", bus.pred_ready_o, 1);
      check_eq("rst_wv", bus.w_v_o, 0);
      check_eq("rst_idx", bus.idx_w_o, 0);
      check_eq("rst_correct", bus.correct_o, 0);
      check_eq("rst_mis", bus.mispredict_o, 0);
      check_eq("rst_uflow", bus.underflow_o, 0);

      for (int i = 0; i < 4; i++) enq(2'(i), exp_taken2[i]);
      check_eq("t1_count_full", bus.count_o, 4);
      check_eq("t1_ready_full", bus.pred_ready_o, 0);
      enq(2'd3, 1'b1);
      check_eq("t1_count_5th", bus.count_o, 4);

      // 2: in-order resolution, all correct
      for (int i = 0; i < 4; i++) begin
         bus.res_v_i     = 1'b1;
         bus.res_taken_i = exp_taken2[i];
         step();
         check_eq("t2_wv", bus.w_v_o, 1);
         check_eq("t2_idx", bus.idx_w_o, i);
         check_eq("t2_correct", bus.correct_o, 1);
         check_eq("t2_mis", bus.mispredict_o, 0);
         check_eq("t2_count", bus.count_o, 3 - i);
      end
      bus.res_v_i = 1'b0;
      step();
      check_eq("t2_wv_idle", bus.w_v_o, 0);

      // 3: mispredict squashes younger entries, then underflow
      enq(2'd1, 1'b1);
      enq(2'd2, 1'b1);
      enq(2'd3, 1'b1);
      check_eq("t3_count3", bus.count_o, 3);
      bus.res_v_i     = 1'b1;
      bus.res_taken_i = 1'b0;
      step();
      check_eq("t3_wv", bus.w_v_o, 1);
      check_eq("t3_idx", bus.idx_w_o, 1);
      check_eq("t3_correct", bus.correct_o, 0);
      check_eq("t3_mis", bus.mispredict_o, 1);
      check_eq("t3_count", bus.count_o, 0);
      bus.res_v_i = 1'b0;
      step();
      check_eq("t3_mis_pulse", bus.mispredict_o, 0);
      check_eq("t3_uflow_pre", bus.underflow_o, 0);
      bus.res_v_i = 1'b1;
      step();
      check_eq("t3_uflow_wv", bus.w_v_o, 0);
      check_eq("t3_uflow", bus.underflow_o, 1);
      bus.res_v_i = 1'b0;
      step();
      check_eq("t3_uflow_sticky", bus.underflow_o, 1);
      check_eq("t3_uflow_count", bus.count_o, 0);

      // 4: full queue with simultaneous enq+deq, wrap-around ordering
      for (int i = 0; i < 4; i++) enq(2'(i), 1'b1);
      check_eq("t4_ready_full", bus.pred_ready_o, 0);
      for (int k = 0; k < 10; k++) begin
         bus.pred_v_i     = 1'b1;
         bus.pred_idx_i   = 2'(k);
         bus.pred_taken_i = 1'b1;
         bus.res_v_i      = 1'b1;
         bus.res_taken_i  = 1'b1;
         step();
         check_eq("t4_wv", bus.w_v_o, 1);
         check_eq("t4_idx", bus.idx_w_o, exp_pop4[k]);
         check_eq("t4_correct", bus.correct_o, 1);
         check_eq("t4_count", bus.count_o, 3);
      end
      bus.pred_v_i = 1'b0;
      for (int k = 0; k < 3; k++) begin
         step();
         check_eq("t4_drain_idx", bus.idx_w_o, exp_drain4[k]);
         check_eq("t4_drain_count", bus.count_o, 2 - k);
      end
      bus.res_v_i = 1'b0;
      step();

      // 5: flush with same-cycle resolution and prediction
      enq(2'd2, 1'b1);
      enq(2'd3, 1'b0);
      bus.flush_i      = 1'b1;
      bus.res_v_i      = 1'b1;
      bus.res_taken_i  = 1'b1;
      bus.pred_v_i     = 1'b1;
      bus.pred_idx_i   = 2'd1;
      bus.pred_taken_i = 1'b1;
      step();
      idle_inputs();
      check_eq("t5_wv", bus.w_v_o, 1);
      check_eq("t5_idx", bus.idx_w_o, 2);
      check_eq("t5_correct", bus.correct_o, 1);
      check_eq("t5_mis", bus.mispredict_o, 0);
      check_eq("t5_count", bus.count_o, 0);
      step();
      check_eq("t5_wv_idle", bus.w_v_o, 0);
      enq(2'd0, 1'b0);
      bus.res_v_i     = 1'b1;
      bus.res_taken_i = 1'b0;
      step();
      bus.res_v_i = 1'b0;
      check_eq("t5_post_idx", bus.idx_w_o, 0);
      check_eq("t5_post_correct", bus.correct_o, 1);
      check_eq("t5_post_count", bus.count_o, 0);

      // 6: reset mid-operation with resolution pending
      enq(2'd1, 1'b1);
      enq(2'd2, 1'b1);
      enq(2'd3, 1'b1);
      rst             = 1'b1;
      bus.res_v_i     = 1'b1;
      bus.res_taken_i = 1'b1;
      step();
      check_eq("t6_wv", bus.w_v_o, 0);
      check_eq("t6_count", bus.count_o, 0);
      check_eq("t6_uflow", bus.underflow_o, 0);
      check_eq("t6_ready", bus.pred_ready_o, 1);
      rst = 1'b0;
      bus.res_v_i = 1'b0;
      step();
      check_eq("t6_post_wv", bus.w_v_o, 0);
      check_eq("t6_post_count", bus.count_o, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
